// File: rtl/axi_mem_loader_pkg.sv
// Shared types and AXI constants for the stream-to-AXI memory loader.
// Burst sizing helper keeps every burst inside one 4 KB page.
package axi_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    DONE
  } state_e;

  localparam logic [1:0]  INCR       = 2'b01;
  localparam logic [2:0]  SIZE_8B    = 3'd3;
  localparam logic [1:0]  OKAY       = 2'b00;
  localparam logic [12:0] PAGE_BYTES = 13'd4096;

  // Beats for the next burst: limited by words left, MAX_BURST and room to the page end.
  function automatic logic [8:0] burst_beats(input logic [15:0] remain,
                                             input logic [11:0] page_off,
                                             input int unsigned max_burst);
    logic [12:0] room;
    logic [15:0] b;
    room = (PAGE_BYTES - {1'b0, page_off}) >> 3;
    b    = remain;
    if (b > 16'(max_burst)) b = 16'(max_burst);
    if (b > {3'b000, room}) b = {3'b000, room};
    return b[8:0];
  endfunction

endpackage

// File: rtl/axi_mem_loader.sv
// Writes a 64-bit data stream to memory over an AXI write channel, one burst
// in flight at a time, splitting the job at MAX_BURST and 4 KB boundaries.
module axi_mem_loader
  import axi_mem_loader_pkg::*;
#(
  parameter int ID_WIDTH  = 6,
  parameter int AXI_ID    = 0,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [31:0]         i_base,
  input  logic [15:0]         i_nwords,
  input  logic [63:0]         i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);

  state_e      r_state;
  logic [31:0] r_awaddr;
  logic [7:0]  r_awlen;
  logic        r_awvalid;
  logic        r_bready;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_remain;
  logic [8:0]  r_beats;
  logic [8:0]  r_beat_cnt;

  logic [8:0]  w_first_beats;
  logic [31:0] w_next_addr;
  logic [15:0] w_next_remain;
  logic [8:0]  w_next_beats;
  logic        w_last_beat;
  logic        w_beat_xfer;
  logic        w_unused;

  assign w_first_beats = burst_beats(i_nwords, i_base[11:0], MAX_BURST);
  assign w_next_addr   = r_awaddr + {20'd0, r_beats, 3'd0};
  assign w_next_remain = r_remain - {7'd0, r_beats};
  assign w_next_beats  = burst_beats(w_next_remain, w_next_addr[11:0], MAX_BURST);
  assign w_last_beat   = (r_beat_cnt == r_beats - 9'd1);
  assign w_beat_xfer   = (r_state == W) && i_valid && i_wready;
  assign w_unused      = ^i_bid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_awaddr   <= '0;
      r_awlen    <= '0;
      r_awvalid  <= 1'b0;
      r_bready   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_remain   <= '0;
      r_beats    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_nwords != 16'd0) begin
              r_awaddr  <= i_base;
              r_remain  <= i_nwords;
              r_beats   <= w_first_beats;
              r_awlen   <= 8'(w_first_beats - 9'd1);
              r_awvalid <= 1'b1;
              r_err     <= 1'b0;
              r_state   <= AW;
            end else begin
              r_state <= DONE;
            end
          end
        end
        AW: begin
          if (i_awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= W;
          end
        end
        W: begin
          if (w_beat_xfer) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (w_last_beat) begin
              r_bready <= 1'b1;
              r_state  <= B;
            end
          end
        end
        B: begin
          if (i_bvalid) begin
            r_bready <= 1'b0;
            if (i_bresp != OKAY) r_err <= 1'b1;
            r_remain <= w_next_remain;
            if (w_next_remain != 16'd0) begin
              r_awaddr  <= w_next_addr;
              r_beats   <= w_next_beats;
              r_awlen   <= 8'(w_next_beats - 9'd1);
              r_awvalid <= 1'b1;
              r_state   <= AW;
            end else begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          // Pulse is registered here, so it lands the cycle after DONE.
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_awid    = ID_WIDTH'(AXI_ID);
  assign o_awaddr  = r_awaddr;
  assign o_awlen   = r_awlen;
  assign o_awsize  = SIZE_8B;
  assign o_awburst = INCR;
  assign o_awvalid = r_awvalid;
  // W channel is a straight pass-through of the stream while in W.
  assign o_wdata   = i_data;
  assign o_wstrb   = 8'hFF;
  assign o_wvalid  = (r_state == W) && i_valid;
  assign o_ready   = (r_state == W) && i_wready;
  assign o_wlast   = (r_state == W) && w_last_beat;
  assign o_bready  = r_bready;
  assign o_busy    = (r_state != IDLE);
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule
